// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV32I pipeline: shadows per-stage state and
// drives pipeline-register enables/flushes plus EX and ID operand bypass selects.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rf_wen,
    input  logic              id_is_load,
    input  logic              ex_jump,
    input  logic              dmem_busy,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mem_wb_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              id_fwd_a,
    output logic              id_fwd_b,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_LOAD_USE = 2'd1,
        MODE_JUMP     = 2'd2,
        MODE_FREEZE   = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic              r_id_v;
    logic              r_ex_v;
    logic [REG_AW-1:0] r_ex_rd;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic              r_ex_rf_wen;
    logic              r_ex_load;
    logic              r_mem_v;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_rf_wen;
    logic              r_mem_load;
    logic              r_wb_v;
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_rf_wen;
    logic [CNT_W-1:0]  r_retire_cnt;

    mode_t w_mode;
    logic  w_load_use;
    logic  w_mem_fwd_ok;
    logic  w_wb_fwd_ok;

    always_comb begin
        w_load_use = r_id_v && r_ex_v && r_ex_load && (r_ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == r_ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == r_ex_rd)));
        // Freeze outranks a jump so a redirect is never lost while memory stalls.
        if (dmem_busy)
            w_mode = MODE_FREEZE;
        else if (r_ex_v && ex_jump)
            w_mode = MODE_JUMP;
        else if (w_load_use)
            w_mode = MODE_LOAD_USE;
        else
            w_mode = MODE_NORMAL;
    end

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (reset) begin
            case (w_mode)
                MODE_FREEZE: begin
                    mem_wb_flush = 1'b1;
                end
                MODE_JUMP: begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    id_ex_en    = 1'b1;
                    ex_mem_en   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                MODE_LOAD_USE: begin
                    id_ex_en    = 1'b1;
                    ex_mem_en   = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                end
            endcase
        end
    end

    // A load in MEM has no data yet, so only WB can bypass its result.
    assign w_mem_fwd_ok = r_mem_v && r_mem_rf_wen && !r_mem_load && (r_mem_rd != '0);
    assign w_wb_fwd_ok  = r_wb_v && r_wb_rf_wen && (r_wb_rd != '0);

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reset && r_ex_v) begin
            if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs1))
                fwd_a = 2'b01;
            else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs1))
                fwd_a = 2'b10;
            if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs2))
                fwd_b = 2'b01;
            else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs2))
                fwd_b = 2'b10;
        end
    end

    assign id_fwd_a   = reset && w_wb_fwd_ok && (r_wb_rd == id_rs1) && id_use_rs1;
    assign id_fwd_b   = reset && w_wb_fwd_ok && (r_wb_rd == id_rs2) && id_use_rs2;
    assign retire_cnt = r_retire_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id_v       <= 1'b0;
            r_ex_v       <= 1'b0;
            r_ex_rd      <= '0;
            r_ex_rs1     <= '0;
            r_ex_rs2     <= '0;
            r_ex_rf_wen  <= 1'b0;
            r_ex_load    <= 1'b0;
            r_mem_v      <= 1'b0;
            r_mem_rd     <= '0;
            r_mem_rf_wen <= 1'b0;
            r_mem_load   <= 1'b0;
            r_wb_v       <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_rf_wen  <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            if (w_mode == MODE_FREEZE) begin
                // WB already wrote this cycle; dropping it avoids a second write.
                r_wb_v <= 1'b0;
            end else begin
                if (r_wb_v)
                    r_retire_cnt <= r_retire_cnt + CNT_ONE;
                r_wb_v       <= r_mem_v;
                r_wb_rd      <= r_mem_rd;
                r_wb_rf_wen  <= r_mem_rf_wen;
                r_mem_v      <= r_ex_v;
                r_mem_rd     <= r_ex_rd;
                r_mem_rf_wen <= r_ex_rf_wen;
                r_mem_load   <= r_ex_load;
            end
            if (w_mode == MODE_NORMAL) begin
                r_ex_v      <= r_id_v;
                r_ex_rd     <= id_rd;
                r_ex_rs1    <= id_rs1;
                r_ex_rs2    <= id_rs2;
                r_ex_rf_wen <= id_rf_wen;
                r_ex_load   <= id_is_load;
                r_id_v      <= 1'b1;
            end else if (w_mode == MODE_JUMP) begin
                r_ex_v <= 1'b0;
                r_id_v <= 1'b0;
            end else if (w_mode == MODE_LOAD_USE) begin
                r_ex_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan scenarios with literal checks,
// then random traffic, all compared every cycle against an instruction-slot model.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;
  localparam int OW = 13;

  localparam int M_RST = 0;
  localparam int M_FRZ = 1;
  localparam int M_JMP = 2;
  localparam int M_LU  = 3;
  localparam int M_NRM = 4;

  logic clk;
  logic reset;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic id_use_rs1;
  logic id_use_rs2;
  logic [AW-1:0] id_rd;
  logic id_rf_wen;
  logic id_is_load;
  logic ex_jump;
  logic dmem_busy;
  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic mem_wb_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic id_fwd_a;
  logic id_fwd_b;
  logic [CW-1:0] retire_cnt;

  pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .id_rd(id_rd),
    .id_rf_wen(id_rf_wen),
    .id_is_load(id_is_load),
    .ex_jump(ex_jump),
    .dmem_busy(dmem_busy),
    .pc_en(pc_en),
    .if_id_en(if_id_en),
    .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .id_fwd_a(id_fwd_a),
    .id_fwd_b(id_fwd_b),
    .retire_cnt(retire_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Slot 0 = ID, 1 = EX, 2 = MEM, 3 = WB. A bubble is an all-zero slot.
  typedef struct packed {
    logic v;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic wen;
    logic load;
  } ins_t;

  ins_t pipe [4];
  int unsigned m_ret;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int cyc = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] act_vec;

  assign act_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
                    mem_wb_flush, fwd_a, fwd_b, id_fwd_a, id_fwd_b};

  function automatic logic reads_reg(input logic use_it, input logic [AW-1:0] src,
                                     input logic [AW-1:0] rd);
    return use_it && (src == rd);
  endfunction

  function automatic int m_mode();
    if (!reset) return M_RST;
    if (dmem_busy) return M_FRZ;
    if (pipe[1].v && ex_jump) return M_JMP;
    if (pipe[0].v && pipe[1].v && pipe[1].load && pipe[1].rd != 0 &&
        (reads_reg(id_use_rs1, id_rs1, pipe[1].rd) || reads_reg(id_use_rs2, id_rs2, pipe[1].rd)))
      return M_LU;
    return M_NRM;
  endfunction

  // Nearest older producer wins; a load still in MEM cannot supply data.
  function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
    if (!pipe[1].v) return 2'b00;
    for (int s = 2; s <= 3; s++) begin
      if (pipe[s].v && pipe[s].wen && pipe[s].rd != 0 && pipe[s].rd == src &&
          !(s == 2 && pipe[s].load))
        return (s == 2) ? 2'b01 : 2'b10;
    end
    return 2'b00;
  endfunction

  function automatic logic m_id_byp(input logic use_it, input logic [AW-1:0] src);
    return pipe[3].v && pipe[3].wen && pipe[3].rd != 0 && pipe[3].rd == src && use_it;
  endfunction

  function automatic logic [OW-1:0] m_expect();
    int m;
    logic [3:0] en;
    logic [2:0] fl;
    m = m_mode();
    if (m == M_RST) return '0;
    case (m)
      M_FRZ:   begin en = 4'b0000; fl = 3'b001; end
      M_JMP:   begin en = 4'b1111; fl = 3'b110; end
      M_LU:    begin en = 4'b0011; fl = 3'b010; end
      default: begin en = 4'b1111; fl = 3'b000; end
    endcase
    return {en, fl, m_fwd(pipe[1].rs1), m_fwd(pipe[1].rs2),
            m_id_byp(id_use_rs1, id_rs1), m_id_byp(id_use_rs2, id_rs2)};
  endfunction

  always @(posedge clk or negedge reset) begin : model_update
    int m;
    ins_t id_rec;
    if (!reset) begin
      for (int i = 0; i < 4; i++) pipe[i] = '0;
      m_ret = 0;
    end else begin
      cyc++;
      m = m_mode();
      id_rec = '{v: pipe[0].v, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                 wen: id_rf_wen, load: id_is_load};
      if (m == M_FRZ) begin
        pipe[3].v = 1'b0;
      end else begin
        if (pipe[3].v) m_ret++;
        pipe[3] = pipe[2];
        pipe[2] = pipe[1];
        pipe[1] = (m == M_NRM) ? id_rec : '0;
        if (m == M_NRM) pipe[0].v = 1'b1;
        else if (m == M_JMP) pipe[0].v = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin : compare
    logic [OW-1:0] e;
    exp_q.push_back(m_expect());
    e = exp_q.pop_front();
    n_vec++;
    if (act_vec !== e) begin
      n_err++;
      $display("FAIL cyc %0d ctrl_vec: got %b expected %b", cyc, act_vec, e);
    end
    n_vec++;
    if (retire_cnt !== m_ret) begin
      n_err++;
      $display("FAIL cyc %0d retire_cnt: got %0d expected %0d", cyc, retire_cnt, m_ret);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic put(input int rs1, input int rs2, input bit u1, input bit u2,
                     input int rd, input bit wen, input bit load);
    id_rs1     = AW'(rs1);
    id_rs2     = AW'(rs2);
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_rd      = AW'(rd);
    id_rf_wen  = wen;
    id_is_load = load;
  endtask

  task automatic nop();
    put(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    ex_jump = 1'b0;
    dmem_busy = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    neg();
    chk("reset_pc_en", pc_en, 0);
    chk("reset_mem_wb_flush", mem_wb_flush, 0);
    chk("reset_retire", retire_cnt, 0);
    step();
    reset = 1'b1;
    step();
    // dependent ALU chain: add x5,x1,x2 ; sub x6,x5,x3
    put(1, 2, 1, 1, 5, 1, 0); step();
    put(5, 3, 1, 1, 6, 1, 0); neg(); chk("chain_no_stall", pc_en, 1); step();
    nop(); neg(); chk("chain_fwd_a", fwd_a, 2'b01); chk("chain_fwd_b", fwd_b, 2'b00); step();
    step(); step();
    // load-use: lw x7,0(x1) ; add x8,x7,x2
    put(1, 0, 1, 0, 7, 1, 1); neg(); chk("chain_retire", retire_cnt, 2); step();
    put(7, 2, 1, 1, 8, 1, 0); neg();
    chk("lu_pc_en", pc_en, 0); chk("lu_if_id_en", if_id_en, 0); chk("lu_id_ex_flush", id_ex_flush, 1);
    step();
    neg(); chk("lu_single_stall", pc_en, 1); step();
    nop(); neg(); chk("lu_fwd_a", fwd_a, 2'b10); step();
    step();
    neg(); chk("lu_retire_hold", retire_cnt, 6); step();
    neg(); chk("lu_retire_done", retire_cnt, 7); step();
    step();
    // taken jump in EX with two younger instructions behind it
    ex_jump = 1'b1; neg();
    chk("jump_if_id_flush", if_id_flush, 1); chk("jump_id_ex_flush", id_ex_flush, 1);
    chk("jump_pc_en", pc_en, 1); step();
    ex_jump = 1'b0; neg(); chk("jump_one_cycle", if_id_flush, 0); step();
    step(); step(); step();
    neg(); chk("jump_retire", retire_cnt, 12); step();
    step();
    // freeze with a load in MEM and a load-use pair in ID/EX
    put(1, 0, 1, 0, 9, 1, 1); step();
    put(1, 0, 1, 0, 10, 1, 1); step();
    put(10, 0, 1, 0, 11, 1, 0); dmem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("frz_pc_en", pc_en, 0); chk("frz_id_ex_en", id_ex_en, 0);
      chk("frz_ex_mem_en", ex_mem_en, 0); chk("frz_mem_wb_flush", mem_wb_flush, 1);
      step();
    end
    dmem_busy = 1'b0; neg();
    chk("frz_then_lu_pc_en", pc_en, 0); chk("frz_then_lu_flush", id_ex_flush, 1);
    step();
    neg(); chk("frz_lu_release", pc_en, 1); step();
    nop(); neg(); chk("frz_load_retire", retire_cnt, 17); step();
    neg(); chk("frz_load2_retire", retire_cnt, 18); step();
    // x0 writers (load, then ALU) followed by x0 readers
    put(0, 0, 0, 0, 0, 1, 1); step();
    put(0, 0, 1, 1, 0, 1, 0); neg(); chk("x0_load_no_stall", pc_en, 1); step();
    put(0, 0, 1, 1, 3, 1, 0); neg(); chk("x0_alu_no_stall", pc_en, 1); step();
    neg();
    chk("x0_fwd_a", fwd_a, 2'b00); chk("x0_fwd_b", fwd_b, 2'b00);
    chk("x0_id_fwd_a", id_fwd_a, 0); chk("x0_id_fwd_b", id_fwd_b, 0);
    step();
    nop(); repeat (4) step();
    // reset mid-stream with every stage occupied
    reset = 1'b0; #1;
    chk("midrst_pc_en", pc_en, 0); chk("midrst_fwd_a", fwd_a, 0); chk("midrst_retire", retire_cnt, 0);
    step();
    reset = 1'b1;
    put(5, 5, 1, 1, 5, 1, 0);
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("postrst_retire", retire_cnt, 0);
      if (k < 3) chk("postrst_fwd_a", fwd_a, 0);
      step();
    end
    // random traffic with occasional reset pulses
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 299) != 0);
      id_rs1     = AW'($urandom_range(0, 3));
      id_rs2     = AW'($urandom_range(0, 3));
      id_use_rs1 = $urandom_range(0, 3) != 0;
      id_use_rs2 = $urandom_range(0, 1) != 0;
      id_rd      = AW'($urandom_range(0, 3));
      id_rf_wen  = $urandom_range(0, 3) != 0;
      id_is_load = $urandom_range(0, 9) < 3;
      ex_jump    = $urandom_range(0, 9) == 0;
      dmem_busy  = $urandom_range(0, 99) < 15;
      step();
    end
    reset = 1'b1;
    dmem_busy = 1'b0;
    ex_jump = 1'b0;
    neg();
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
